// File: rtl/button_conditioner_pkg.sv
// Shared state encodings for the button conditioner and the output-timer FSM it feeds.
package button_conditioner_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] S_IDLE         = 2'd0;
  localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] S_PRESSED      = 2'd2;
  localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

  // Downstream output-timer FSM, driven by the B pulse.
  localparam logic [1:0] T_IDLE   = 2'd0;
  localparam logic [1:0] T_LOAD   = 2'd1;
  localparam logic [1:0] T_RUN    = 2'd2;
  localparam logic [1:0] T_EXPIRE = 2'd3;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; both flops clear on reset.
module sync_2ff (
  input  logic Clk,
  input  logic Rst,
  input  logic D,
  output logic Q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= D;
      r_sync <= r_meta;
    end
  end

  assign Q = r_sync;

endmodule

// File: rtl/button_conditioner.sv
// Debounces a raw push-button into a registered level and a single-cycle press pulse.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       BtnIn,
  output logic       B,
  output logic       BtnLevel,
  output logic [1:0] State
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             w_sync;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_b;
  logic             r_level;
  logic             w_press_accept;

  sync_2ff u_sync (
    .Clk (Clk),
    .Rst (Rst),
    .D   (BtnIn),
    .Q   (w_sync)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_press_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_sync) begin
          w_state_nxt = S_PRESS_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      S_PRESS_WAIT: begin
        if (!w_sync) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt    = S_PRESSED;
          w_press_accept = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_PRESSED: begin
        if (!w_sync) begin
          w_state_nxt = S_RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        // Release bounce returns to Pressed without a pulse.
        if (w_sync) begin
          w_state_nxt = S_PRESSED;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_b     <= 1'b0;
      r_level <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_b     <= w_press_accept;
      r_level <= (w_state_nxt == S_PRESSED) || (w_state_nxt == S_RELEASE_WAIT);
    end
  end

  assign B        = r_b;
  assign BtnLevel = r_level;
  assign State    = r_state;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4.
module tb_button_conditioner;

  logic       Clk;
  logic       Rst;
  logic       BtnIn;
  logic       B;
  logic       BtnLevel;
  logic [1:0] State;

  int n_tests;
  int n_fail;
  int n_pulses;

  button_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (16)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .BtnIn    (BtnIn),
    .B        (B),
    .BtnLevel (BtnLevel),
    .State    (State)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic edge_sample();
    @(posedge Clk);
    #1;
    if (B === 1'b1) n_pulses++;
  endtask

  // Set the raw button on a falling edge, away from sampling.
  task automatic drive(input logic v);
    @(negedge Clk);
    BtnIn = v;
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    n_pulses = 0;
    Rst      = 1'b0;
    BtnIn    = 1'b0;

    #2;
    chk("reset_state", 32'(State), 32'd0);
    chk("reset_b", 32'(B), 32'd0);
    chk("reset_level", 32'(BtnLevel), 32'd0);

    @(negedge Clk);
    Rst = 1'b1;
    repeat (3) edge_sample();
    chk("idle_state", 32'(State), 32'd0);

    // Clean press, held 20 cycles: B only after edge 6.
    n_pulses = 0;
    drive(1'b1);
    for (int i = 0; i < 20; i++) begin
      edge_sample();
      chk($sformatf("press_b_%0d", i), 32'(B), 32'(i == 6));
      chk($sformatf("press_lvl_%0d", i), 32'(BtnLevel), 32'(i >= 6));
      chk($sformatf("press_st_%0d", i), 32'(State), (i < 2) ? 32'd0 : (i < 6) ? 32'd1 : 32'd2);
    end
    chk("press_pulse_count", 32'(n_pulses), 32'd1);

    // Steady release: level falls after edge 6.
    drive(1'b0);
    for (int i = 0; i < 10; i++) begin
      edge_sample();
      chk($sformatf("rel_lvl_%0d", i), 32'(BtnLevel), 32'(i < 6));
      chk($sformatf("rel_st_%0d", i), 32'(State), (i < 2) ? 32'd2 : (i < 6) ? 32'd3 : 32'd0);
      chk($sformatf("rel_b_%0d", i), 32'(B), 32'd0);
    end

    // Press bounce: high 2, low 1, then steady high from edge 3; pulse after edge 9.
    n_pulses = 0;
    drive(1'b1);
    edge_sample();
    chk("bnc_b_0", 32'(B), 32'd0);
    edge_sample();
    chk("bnc_b_1", 32'(B), 32'd0);
    BtnIn = 1'b0;
    @(negedge Clk);
    BtnIn = 1'b0;
    edge_sample();
    chk("bnc_b_2", 32'(B), 32'd0);
    @(negedge Clk);
    BtnIn = 1'b1;
    for (int i = 3; i < 16; i++) begin
      edge_sample();
      chk($sformatf("bnc_b_%0d", i), 32'(B), 32'(i == 9));
      if (i == 4) chk("bnc_reject_st", 32'(State), 32'd0);
    end
    chk("bnc_pulse_count", 32'(n_pulses), 32'd1);
    chk("bnc_state", 32'(State), 32'd2);

    // Release bounce from held: low 2 cycles then high again.
    n_pulses = 0;
    drive(1'b0);
    edge_sample();
    edge_sample();
    chk("rbnc_st_1", 32'(State), 32'd2);
    @(negedge Clk);
    BtnIn = 1'b1;
    for (int i = 2; i < 12; i++) begin
      if (i > 2) edge_sample();
      else begin
        @(posedge Clk);
        #1;
        if (B === 1'b1) n_pulses++;
      end
      chk($sformatf("rbnc_lvl_%0d", i), 32'(BtnLevel), 32'd1);
      chk($sformatf("rbnc_b_%0d", i), 32'(B), 32'd0);
      if (i == 2 || i == 3) chk($sformatf("rbnc_st_%0d", i), 32'(State), 32'd3);
      if (i >= 4) chk($sformatf("rbnc_st_%0d", i), 32'(State), 32'd2);
    end
    chk("rbnc_pulse_count", 32'(n_pulses), 32'd0);

    // Back to idle.
    drive(1'b0);
    repeat (10) edge_sample();
    chk("idle2_state", 32'(State), 32'd0);

    // Reset asserted mid-debounce, press held through it.
    drive(1'b1);
    repeat (3) edge_sample();
    chk("mid_state", 32'(State), 32'd1);
    #2;
    Rst = 1'b0;
    #1;
    chk("async_rst_state", 32'(State), 32'd0);
    chk("async_rst_b", 32'(B), 32'd0);
    chk("async_rst_level", 32'(BtnLevel), 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    n_pulses = 0;
    for (int i = 0; i < 10; i++) begin
      edge_sample();
      chk($sformatf("rst_b_%0d", i), 32'(B), 32'(i == 6));
      if (i == 1) chk("rst_st_1", 32'(State), 32'd0);
    end
    chk("rst_pulse_count", 32'(n_pulses), 32'd1);

    drive(1'b0);
    repeat (10) edge_sample();
    chk("idle3_state", 32'(State), 32'd0);

    // Back-to-back clean presses with 10 low cycles between.
    n_pulses = 0;
    for (int p = 0; p < 2; p++) begin
      drive(1'b1);
      for (int i = 0; i < 12; i++) begin
        edge_sample();
        chk($sformatf("b2b%0d_b_%0d", p, i), 32'(B), 32'(i == 6));
      end
      drive(1'b0);
      for (int i = 0; i < 10; i++) begin
        edge_sample();
        chk($sformatf("b2b%0d_low_b_%0d", p, i), 32'(B), 32'd0);
      end
    end
    chk("b2b_pulse_count", 32'(n_pulses), 32'd2);
    chk("b2b_final_state", 32'(State), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, is the number of consecutive stable synchronized samples required to accept a level change; legal range 2..65535.
REQ-002 Parameter CNT_W, default 16, is the debounce counter width; it SHALL satisfy 2^CNT_W > DEBOUNCE_CYCLES.
REQ-003 Port Clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port Rst  input  1  asynchronous, active-low reset.
REQ-005 Port BtnIn  input  1  raw, asynchronous, bouncing push-button level.
REQ-006 Port B  output  1  registered single-cycle press pulse, fed to the downstream output-timer FSM's B input.
REQ-007 Port BtnLevel  output  1  registered debounced button level.
REQ-008 Port State  output  2  current conditioner state, for debug.

Function
REQ-009 BtnIn SHALL pass through a two-flop synchronizer; only its output (Sync) SHALL be used by the FSM.
REQ-010 The FSM SHALL have four states: S_Idle=0, S_PressWait=1, S_Pressed=2, S_ReleaseWait=3.
REQ-011 S_Idle: Sync=1 -> S_PressWait with Cnt cleared to 0; otherwise stay.
REQ-012 S_PressWait: Sync=0 -> S_Idle (bounce rejected, no pulse).
REQ-013 In S_PressWait, Sync=1 with Cnt < DEBOUNCE_CYCLES-1 -> Cnt increments by 1.
REQ-014 In S_PressWait, Sync=1 with Cnt = DEBOUNCE_CYCLES-1 -> S_Pressed.
REQ-015 S_Pressed: Sync=0 -> S_ReleaseWait with Cnt cleared to 0; otherwise stay.
REQ-016 S_ReleaseWait: Sync=1 -> S_Pressed (release bounce rejected, no pulse).
REQ-017 In S_ReleaseWait, Sync=0 with Cnt < DEBOUNCE_CYCLES-1 -> Cnt increments by 1.
REQ-018 In S_ReleaseWait, Sync=0 with Cnt = DEBOUNCE_CYCLES-1 -> S_Idle.
REQ-019 B SHALL be 1 for exactly one cycle: the first cycle in S_Pressed after the S_PressWait -> S_Pressed transition; it SHALL NOT assert on S_ReleaseWait -> S_Pressed.
REQ-020 B SHALL not reassert while the button is held, for any hold duration.
REQ-021 BtnLevel SHALL be 1 in S_Pressed and S_ReleaseWait and 0 in S_Idle and S_PressWait, registered and aligned with State.
REQ-022 Latency: with BtnIn stable high from before rising edge 0 and Idle at edge 0, B SHALL be high in the cycle following edge DEBOUNCE_CYCLES+2.
REQ-023 Cnt SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL not wrap.
REQ-024 Outputs SHALL depend on no combinational path from BtnIn.

Reset
REQ-025 Rst=0 SHALL immediately force State=S_Idle, Cnt=0, B=0, BtnLevel=0, and both synchronizer flops to 0, regardless of Clk.
REQ-026 A reset asserted during S_PressWait SHALL produce no B pulse; after release, a press still held SHALL be re-debounced from S_Idle.
REQ-027 Reset deassertion SHALL take effect on the first rising Clk edge after Rst returns to 1.

Structure
REQ-028 State encodings S_Idle..S_ReleaseWait SHALL live in a shared constants package/include, together with the downstream FSM's state constants.
REQ-029 The two-flop synchronizer SHALL be a separate sub-module, sync_2ff (ports Clk, Rst, D, Q; resets Q to 0).
REQ-030 Everything else SHALL be a single module with one sequential always block (async reset) and one combinational next-state block.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 Clean press: BtnIn 0->1 before edge 0, held 20 cycles -> B high only in the cycle after edge 6; BtnLevel high from that cycle on; State=2.
REQ-032 Press bounce: BtnIn high 2 cycles, low 1 cycle, then high steady -> no B during the bounce; exactly one B pulse 7 cycles after the final rising edge of BtnIn.
REQ-033 Release bounce: from held, BtnIn low 2 cycles then high -> State returns to 2, BtnLevel stays 1, B stays 0.
REQ-034 Release: from held, BtnIn low steady -> BtnLevel falls 7 cycles after the falling edge of BtnIn; State=0; B stays 0.
REQ-035 Reset mid-debounce: Rst=0 asynchronously while State=1 -> all outputs 0 immediately; with BtnIn still high after release, one B pulse 7 cycles after the reset-release edge.
REQ-036 Back-to-back presses: two clean presses separated by 10 cycles low -> exactly two B pulses, each one cycle wide.
